or3_event_monitor: RTL
======================

// Module: or3_event_monitor
// PURPOSE
//  Sequential front/back stage for the 3-input OR gate. It synchronises and debounces three raw
//  request lines A/B/C and drives the registered OR of the cleaned levels on Y. It also detects
//  the rising edge of Y and keeps a sticky per-channel record plus a saturating event count,
//  which software clears through a CLR/ACK handshake.
// PARAMETERS
//  CNT_W     8  width of the COUNT event counter (>=1)
//  DEBOUNCE  4  consecutive stable cycles needed to accept a new level (>=1)
// PORTS
//  CLK     in   1      single clock, all logic on rising edge
//  RST     in   1      synchronous, active-high reset
//  A       in   1      raw request channel 0 (asynchronous to CLK)
//  B       in   1      raw request channel 1
//  C       in   1      raw request channel 2
//  CLR     in   1      clear request for STICKY/COUNT (level, edge-detected internally)
//  Y       out  1      registered OR of debounced (unmasked) channels
//  RISE    out  1      one-cycle pulse on each 0->1 transition of Y
//  STICKY  out  3      {C,B,A} latched debounced rising edge seen since last clear
//  COUNT   out  CNT_W  number of RISE pulses since last clear, saturating
//  ACK     out  1      one-cycle pulse confirming a clear was performed
// BEHAVIOUR
//  - Reset: when RST=1 at an edge, all state clears. Sync flops, debounced levels, debounce
//    counters, FSM=IDLE, Y=0, RISE=0, STICKY=0, COUNT=0, ACK=0 and the CLR history flop are
//    all cleared. RST mid-operation aborts everything.
//  - After reset, an input still held high is re-detected after the full latency below and
//    produces a fresh RISE.
//  - Sync: each channel passes through a 2-flop synchroniser (s_i).
//  - Debounce, per channel: a counter increments while s_i != deb_i and clears when
//    s_i == deb_i. deb_i takes the value of s_i when the counter would reach DEBOUNCE.
//    Pulses on s_i shorter than DEBOUNCE cycles are ignored.
//  - Latency: raw change to Y change = DEBOUNCE+3 edges (2 sync + DEBOUNCE + 1 FSM register).
//  - FSM, 2 states:
//    - IDLE (Y=0) -> ACTIVE when any = |deb_eff. Y<=1 and RISE<=1 on the same edge.
//    - ACTIVE (Y=1) -> IDLE when any = 0. Y<=0; RISE stays 0.
//    - RISE is 1 for exactly one cycle per IDLE->ACTIVE transition.
//  - STICKY[i] is set on the edge where deb_i goes 0->1.
//  - COUNT increments by 1 with each RISE and holds at 2^CNT_W-1; it never wraps.
//  - Clear: on an edge where CLR=1 and clr_q=0 (clr_q = CLR of the previous cycle),
//    STICKY<=0, COUNT<=0 and ACK<=1 for one cycle.
//    - Holding CLR high does nothing further. A new clear needs CLR to return to 0 first.
//  - Simultaneous clear and event on the same edge: the event wins. The relevant STICKY bit
//    ends at 1, COUNT ends at 1 (RISE case), and ACK is still pulsed.
//  - Channels are independent. Several deb_i rising on one edge set several STICKY bits but
//    give only one RISE if Y was 0.
// CONFIGURATION
//  - ORG3_MASK_EN defined: adds input MASK[2:0] ({C,B,A}, 1 = masked).
//    - deb_eff = deb & ~MASK, so a masked channel cannot assert Y, RISE or COUNT.
//    - STICKY still records a masked channel.
//    - Masking the only active channel while in ACTIVE drops Y on the next edge.
//  - ORG3_MASK_EN undefined: there is no MASK port and deb_eff = deb.
// TESTING
//  1. RST=1 2 cycles, A=B=C=0 -> Y=0, RISE=0, STICKY=000, COUNT=0, ACK=0.
//  2. DEBOUNCE=4, A 0->1 held -> Y=1 at edge 7, RISE=1 on that cycle only, STICKY=001, COUNT=1.
//  3. B pulsed high 3 cycles, then low -> Y stays 0, STICKY=000, COUNT=0.
//  4. 300 separate A pulses of 10 cycles, CNT_W=8 -> COUNT saturates at 255 and stays there.
//  5. STICKY=011, COUNT=5; CLR held 5 cycles -> one ACK, STICKY=000, COUNT=0.
//     Clear on the same edge as a C rise -> STICKY=100, COUNT=1, ACK=1.
//  6. Y=1 via A; RST for 1 cycle mid-operation -> all outputs 0.
//     Y re-asserts 7 edges after RST drops, with RISE and COUNT=1.
//     With ORG3_MASK_EN and MASK=001, A high -> Y=0 and STICKY=001.

Source files
------------

// File: rtl/or3_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : or3_event_monitor
// Description : Synchronised, debounced 3-input OR with rising-edge detect,
//               sticky per-channel record and saturating event counter
//               cleared by a CLR/ACK handshake. Optional ORG3_MASK_EN adds
//               a per-channel MASK input.
// Revision    : 1.0 - initial release
// ============================================================================
module or3_event_monitor #(
    parameter int CNT_W    = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             CLR,
`ifdef ORG3_MASK_EN
    input  logic [2:0]       MASK,
`endif
    output logic             Y,
    output logic             RISE,
    output logic [2:0]       STICKY,
    output logic [CNT_W-1:0] COUNT,
    output logic             ACK
);

    localparam int                c_DB_W    = $clog2(DEBOUNCE + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       w_deb;
    logic [2:0]       w_deb_set;
    logic [2:0]       w_deb_eff;
    logic             w_any;
    logic             w_clr_evt;
    logic             w_rise_nxt;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rise;
    logic             r_clr_q;
    logic             r_ack;
    logic [2:0]       r_sticky;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {C, B, A};
            r_sync2 <= r_sync1;
        end
    end

    // A new level is accepted only after DEBOUNCE consecutive disagreeing cycles.
    for (genvar i = 0; i < 3; i++) begin : g_chan
        logic [c_DB_W-1:0] r_cnt;
        logic              r_deb;

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_cnt <= '0;
                r_deb <= 1'b0;
            end else if (r_sync2[i] != r_deb) begin
                if (r_cnt == c_DB_LAST) begin
                    r_deb <= r_sync2[i];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign w_deb[i]     = r_deb;
        assign w_deb_set[i] = r_sync2[i] & ~r_deb & (r_cnt == c_DB_LAST);
    end

`ifdef ORG3_MASK_EN
    assign w_deb_eff = w_deb & ~MASK;
`else
    assign w_deb_eff = w_deb;
`endif

    assign w_any     = |w_deb_eff;
    assign w_clr_evt = CLR & ~r_clr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_rise  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rise  <= w_rise_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rise_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_ACTIVE;
                    w_rise_nxt  = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!w_any) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A clear coinciding with an event keeps the event: it is applied after the clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_clr_q  <= 1'b0;
            r_ack    <= 1'b0;
            r_sticky <= '0;
            r_count  <= '0;
        end else begin
            r_clr_q  <= CLR;
            r_ack    <= w_clr_evt;
            r_sticky <= (w_clr_evt ? 3'b000 : r_sticky) | w_deb_set;
            if (w_clr_evt) begin
                r_count <= w_rise_nxt ? CNT_W'(1) : '0;
            end else if (w_rise_nxt && (r_count != c_CNT_MAX)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign Y      = (r_state == S_ACTIVE);
    assign RISE   = r_rise;
    assign STICKY = r_sticky;
    assign COUNT  = r_count;
    assign ACK    = r_ack;

endmodule
`default_nettype wire
